mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-ported unified data memory between two requesters: port 0 (CPU load/store unit)
//  and port 1 (loader/debug port that preloads programs and inspects memory).
//  Serialises accesses through a small FSM; one access in flight at a time.
//  Drives the memory's enable, byte-write-select, address and write-data lines; returns read data with a valid pulse.
// PARAMETERS
//  AW      8   address width (byte address)
//  DW      64  data width
//  RD_LAT  1   memory read latency in cycles, >=1; mem_rdata valid RD_LAT cycles after the mem_en cycle
// PORTS
//  clk        in   1   clock, all state changes on rising edge
//  reset      in   1   asynchronous, active-low reset
//  m0_req     in   1   port 0 request; held until m0_gnt
//  m0_we      in   2   00 read, 01 32-bit write, 10 64-bit write, 11 reserved (passed through)
//  m0_addr    in   AW  port 0 byte address
//  m0_wdata   in   DW  port 0 write data
//  m0_gnt     out  1   1-cycle pulse: port 0 access issued to memory
//  m0_rvalid  out  1   1-cycle pulse: m0_rdata valid
//  m0_rdata   out  DW  port 0 read data (holds last value)
//  m1_*       same set as m0_* for port 1
//  mem_en     out  1   memory access strobe
//  mem_we     out  2   memory write select (m*_we of winner)
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data
//  busy       out  1   1 whenever FSM is not IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; every output 0 (gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy).
//  States: IDLE -> ISSUE -> (write) IDLE | (read) WAIT -> IDLE.
//  IDLE: if any req, pick winner, latch its we/addr/wdata and port id, go ISSUE. No req -> stay.
//  ISSUE (exactly 1 cycle): mem_en=1, mem_we/addr/wdata = latched; winner's gnt=1.
//    latched we!=00 -> IDLE next; we==00 -> WAIT, counter loaded RD_LAT-1.
//  WAIT: RD_LAT cycles; on last WAIT cycle mem_rdata captured into winner's rdata reg; next cycle
//    (state IDLE) winner's rvalid=1 for one cycle. Read: req sampled cycle T -> gnt at T+1 -> rvalid at T+2+RD_LAT.
//  IDLE may accept a new request in the same cycle rvalid pulses (back-to-back).
//  Outside ISSUE: mem_en=0, mem_we=00; mem_addr/mem_wdata hold latched values.
//  Arbitration default: fixed priority, port 0 wins on simultaneous req; port 1 can starve.
//  Latched command is committed: dropping req after the IDLE sample does not cancel the access.
//  Requester must hold req/we/addr/wdata stable until its gnt; gnt is never given to a non-requesting port.
//  Only one of m0_gnt/m1_gnt, and one of m0_rvalid/m1_rvalid, high in any cycle.
//  Reset mid-operation: in-flight access abandoned, no rvalid produced, requester re-requests.
//  Reserved we=11 forwarded unchanged and treated as write (no WAIT).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: last-winner register (reset to port 1 so port 0 wins first collision);
//    on simultaneous req the port not granted last wins. Single req behaves as default.
//  Undefined: fixed priority port 0 as above; no last-winner register.
// TESTING
//  1 reset low 22 ns, reqs active -> all outputs 0, busy 0, no gnt until reset released.
//  2 m0 write we=01 addr 84 wdata 7 -> next cycle m0_gnt=1, mem_en=1, mem_we=01, mem_addr=84, mem_wdata=7; busy 0 after.
//  3 m1 read addr 80, RD_LAT=1, memory returns 1 -> m1_gnt at T+1, m1_rvalid=1 with m1_rdata=1 at T+3 only.
//  4 m0 and m1 req same cycle (writes addr 128/80) -> m0 first, m1_gnt two cycles later; with macro a second collision grants m1 first.
//  5 m0 held continuously + m1 req -> m1 never granted (default); with ARB_ROUND_ROBIN_EN grants alternate.
//  6 reset pulsed low during WAIT of m0 read -> no m0_rvalid, FSM IDLE, mem_en 0; reissued read completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two requesters onto a single-ported data memory.
// One access in flight at a time: IDLE -> ISSUE -> (write) IDLE | (read) WAIT -> IDLE.
// Optional macro ARB_ROUND_ROBIN_EN: on simultaneous requests the port not granted
// last wins; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 64,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [1:0]    m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [1:0]    m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic [1:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            port_q, port_d;      // 0: port 0 owns the access, 1: port 1
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rvalid0_q, rvalid0_d;
  logic            rvalid1_q, rvalid1_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic            win;
`ifdef ARB_ROUND_ROBIN_EN
  logic            last_q, last_d;
`endif

  // Pick the winning port; only consulted when at least one port requests.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (m0_req && m1_req) win = ~last_q;
    else                  win = ~m0_req;
`else
    win = ~m0_req;
`endif
  end

  // Next-state and datapath update for the access sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    port_d    = port_q;
    cnt_d     = cnt_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          port_d  = win;
          we_d    = win ? m1_we    : m0_we;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = win;
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Reserved code 11 is forwarded as-is and completes like a write.
        if (we_q == 2'b00) begin
          cnt_d   = CW'(RD_LAT - 1);
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (port_q) begin
            rdata1_d  = mem_rdata;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_rdata;
            rvalid0_d = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      port_q    <= 1'b0;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= 1'b1;  // port 0 wins the first collision
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      port_q    <= port_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  // Memory strobes exist only in ISSUE; address and data hold the latched command.
  assign mem_en    = (state_q == S_ISSUE);
  assign mem_we    = mem_en ? we_q : 2'b00;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_gnt    = mem_en & ~port_q;
  assign m1_gnt    = mem_en &  port_q;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign busy      = (state_q != S_IDLE);

endmodule
